// File: rtl/mm4_argmax_reader_pkg.sv
// mm4_argmax_reader_pkg: shared definitions for the layer-4 logit argmax reader.
// Holds the FSM state encoding and the default geometry of the logit store.
package mm4_argmax_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int NUM_CLASSES_DEF = 10;
  localparam int DATA_W_DEF      = 32;
  localparam int ADDR_W_DEF      = 16;
  localparam int CLASS_W_DEF     = 4;

endpackage

// File: rtl/mm4_argmax_reader_if.sv
// mm4_argmax_reader_if: control handshake, result and logit-memory read port of
// the argmax reader. The reader connects through the master modport; the
// requester/memory side connects through the slave modport.
interface mm4_argmax_reader_if #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 16,
  parameter int CLASS_W = 4
);
  logic                     start;
  logic        [ADDR_W-1:0] rd_addr;
  logic signed [DATA_W-1:0] rd_data;
  logic                     busy;
  logic                     done;
  logic       [CLASS_W-1:0] class_out;
  logic signed [DATA_W-1:0] max_val;
  logic                     result_valid;

  modport master (
    input  start, rd_data,
    output rd_addr, busy, done, class_out, max_val, result_valid
  );

  modport slave (
    output start, rd_data,
    input  rd_addr, busy, done, class_out, max_val, result_valid
  );
endinterface

// File: rtl/mm4_argmax_reader_cmp_stage.sv
// argmax_cmp_stage: registered running maximum. An init strobe loads the first
// candidate unconditionally; later candidates replace it only when strictly
// greater (signed), so ties keep the earliest index.
module argmax_cmp_stage #(
  parameter int DATA_W  = 32,
  parameter int CLASS_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     vld,
  input  logic                     init,
  input  logic signed [DATA_W-1:0] din,
  input  logic       [CLASS_W-1:0] idx,
  output logic signed [DATA_W-1:0] best_val,
  output logic       [CLASS_W-1:0] best_idx
);

  logic take;

  assign take = vld && (init || (din > best_val));

  // Best-so-far register: load on init or on a strictly greater candidate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_val <= '0;
      best_idx <= '0;
    end else if (take) begin
      best_val <= din;
      best_idx <= idx;
    end
  end

endmodule

// File: rtl/mm4_argmax_reader.sv
// mm4_argmax_reader: sweeps the layer-4 logit memory and reports the index and
// value of the largest signed logit.
// Build option: define ARGMAX_RDLAT1_EN when the memory read port is
// registered (1-cycle latency); the compare is then fed from a delayed
// index/valid tag so each sample lines up with the address that produced it.
module mm4_argmax_reader
  import mm4_argmax_reader_pkg::*;
#(
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int BASE_ADDR   = 0,
  parameter int CLASS_W     = CLASS_W_DEF
) (
  input logic                clk,
  input logic                rst_n,
  mm4_argmax_reader_if.master bus
);

  localparam logic [CLASS_W-1:0] LAST_IDX = CLASS_W'(NUM_CLASSES - 1);

  state_t               state;
  logic   [CLASS_W-1:0] index;
  logic                 issue;
  logic                 cmp_vld;
  logic   [CLASS_W-1:0] cmp_idx;
  logic                 cmp_init;
  logic                 cmp_last;
  logic signed [DATA_W-1:0] best_val;
  logic       [CLASS_W-1:0] best_idx;

  // index is parked at 0 outside a scan, so the address never leaves the logit range
  assign bus.rd_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(index);

`ifdef ARGMAX_RDLAT1_EN
  logic                 issue_en;
  logic                 vld_p1;
  logic   [CLASS_W-1:0] idx_p1;

  assign issue = (state == ST_SCAN) && issue_en;

  // p1: tag travels one cycle behind the address to meet the registered read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      idx_p1 <= '0;
    end else begin
      vld_p1 <= issue;
      idx_p1 <= index;
    end
  end

  assign cmp_vld = vld_p1;
  assign cmp_idx = idx_p1;
`else
  assign issue   = (state == ST_SCAN);
  assign cmp_vld = issue;
  assign cmp_idx = index;
`endif

  assign cmp_init = cmp_vld && (cmp_idx == '0);
  assign cmp_last = cmp_vld && (cmp_idx == LAST_IDX);

  argmax_cmp_stage #(
    .DATA_W  (DATA_W),
    .CLASS_W (CLASS_W)
  ) u_cmp (
    .clk      (clk),
    .rst_n    (rst_n),
    .vld      (cmp_vld),
    .init     (cmp_init),
    .din      (bus.rd_data),
    .idx      (cmp_idx),
    .best_val (best_val),
    .best_idx (best_idx)
  );

  assign bus.class_out = best_idx;
  assign bus.max_val   = best_val;

  // Scan FSM and address counter; done/busy/result_valid are registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      index            <= '0;
      bus.busy         <= 1'b0;
      bus.done         <= 1'b0;
      bus.result_valid <= 1'b0;
`ifdef ARGMAX_RDLAT1_EN
      issue_en         <= 1'b0;
`endif
    end else begin
      bus.done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state            <= ST_SCAN;
            index            <= '0;
            bus.busy         <= 1'b1;
            bus.result_valid <= 1'b0;
`ifdef ARGMAX_RDLAT1_EN
            issue_en         <= 1'b1;
`endif
          end
        end
        ST_SCAN: begin
          if (issue) begin
            if (index == LAST_IDX) begin
              index <= '0;
`ifdef ARGMAX_RDLAT1_EN
              issue_en <= 1'b0;
`endif
            end else begin
              index <= index + 1'b1;
            end
          end
          if (cmp_last) begin
            state            <= ST_FINISH;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b1;
            bus.result_valid <= 1'b1;
          end
        end
        ST_FINISH: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mm4_argmax_reader.sv
// tb_mm4_argmax_reader: scoreboard bench for the logit argmax reader.
module tb_mm4_argmax_reader;

  localparam int N       = 10;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 16;
  localparam int CLASS_W = 4;
  localparam int BASE    = 0;
`ifdef ARGMAX_RDLAT1_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  typedef logic signed [DATA_W-1:0] vec_t [N];
  typedef struct {
    logic [CLASS_W-1:0]       cls;
    logic signed [DATA_W-1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic signed [DATA_W-1:0] mem [0:15];
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;

  mm4_argmax_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CLASS_W(CLASS_W)) bus_if ();

  mm4_argmax_reader #(
    .NUM_CLASSES (N),
    .DATA_W      (DATA_W),
    .ADDR_W      (ADDR_W),
    .BASE_ADDR   (BASE),
    .CLASS_W     (CLASS_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

`ifdef ARGMAX_RDLAT1_EN
  logic signed [DATA_W-1:0] rd_q = '0;
  always_ff @(posedge clk) rd_q <= mem[bus_if.rd_addr[3:0]];
  assign bus_if.rd_data = rd_q;
`else
  assign bus_if.rd_data = mem[bus_if.rd_addr[3:0]];
`endif

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int k = 0; k < 16; k++) mem[k] = (k < N) ? v[k] : '0;
  endtask

  function automatic exp_t model();
    exp_t r;
    r.cls = '0;
    r.val = mem[0];
    for (int k = 1; k < N; k++)
      if (mem[k] > r.val) begin
        r.val = mem[k];
        r.cls = CLASS_W'(k);
      end
    return r;
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, bus_if.busy, 0);
    chk({tag, "_done"}, bus_if.done, 0);
    chk({tag, "_class"}, bus_if.class_out, 0);
    chk({tag, "_max"}, bus_if.max_val, 0);
    chk({tag, "_rv"}, bus_if.result_valid, 0);
    chk({tag, "_addr"}, bus_if.rd_addr, BASE);
  endtask

  // One full scan; expectation is pushed when start is driven, popped on done.
  // repulse_at >= 0 raises start again in that cycle of the scan.
  task automatic run_scan(input string tag, input int repulse_at, input exp_t e);
    int done_cnt;
    exp_t got_e;
    sb.push_back(e);
    done_cnt = 0;
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    for (int j = 0; j <= N + LAT + 3; j++) begin
      bus_if.start = (j == repulse_at);
      chk({tag, "_addr"}, bus_if.rd_addr, (j < N) ? BASE + j : BASE);
      chk({tag, "_busy"}, bus_if.busy, (j < N + LAT) ? 1 : 0);
      chk({tag, "_rv"}, bus_if.result_valid, (j >= N + LAT) ? 1 : 0);
      chk({tag, "_done_at"}, bus_if.done, (j == N + LAT) ? 1 : 0);
      if (bus_if.done) begin
        done_cnt++;
        if (sb.size() == 0) begin
          chk({tag, "_sb_empty"}, 1, 0);
        end else begin
          got_e = sb.pop_front();
          chk({tag, "_class"}, bus_if.class_out, got_e.cls);
          chk({tag, "_max"}, bus_if.max_val, got_e.val);
        end
      end
      @(negedge clk);
    end
    bus_if.start = 1'b0;
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_hold_class"}, bus_if.class_out, e.cls);
    chk({tag, "_hold_max"}, bus_if.max_val, e.val);
  endtask

  function automatic exp_t mk(input int c, input logic signed [DATA_W-1:0] v);
    exp_t r;
    r.cls = CLASS_W'(c);
    r.val = v;
    return r;
  endfunction

  initial begin
    vec_t v;
    exp_t e;
    bus_if.start = 1'b0;
    for (int k = 0; k < 16; k++) mem[k] = '0;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    v = '{32'sd10, -32'sd3, 32'sd7, 32'sd42, 32'sd0, 32'sd5, -32'sd1, 32'sd41, 32'sd2, 32'sd9};
    load(v);
    run_scan("basic", -1, mk(3, 32'sd42));

    for (int k = 0; k < N; k++) v[k] = 32'sd5;
    load(v);
    run_scan("ties", -1, mk(0, 32'sd5));

    v = '{-32'sd100, -32'sd7, 32'sh80000000, -32'sd8, -32'sd20, -32'sd30, -32'sd40, -32'sd50, -32'sd60, -32'sd9};
    load(v);
    run_scan("neg", -1, mk(1, -32'sd7));

    v = '{32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000, 32'sh80000000,
          32'sh7fffffff, 32'sh80000000, 32'sh7fffffff, 32'sh80000000, 32'sh80000000};
    load(v);
    run_scan("extreme", -1, mk(5, 32'sh7fffffff));

    for (int k = 0; k < N; k++) v[k] = DATA_W'(k * 3 - 4);
    load(v);
    run_scan("last", -1, mk(9, 32'sd23));

    v = '{32'sd10, -32'sd3, 32'sd7, 32'sd42, 32'sd0, 32'sd5, -32'sd1, 32'sd41, 32'sd2, 32'sd9};
    load(v);
    run_scan("repulse", 3, mk(3, 32'sd42));

    // Reset in the middle of a scan: outputs clear without a clock edge, no done follows
    @(negedge clk);
    bus_if.start = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_pre_busy", bus_if.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    check_zero("midrst");
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("midrst_nodone", bus_if.done, 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("postrst");

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < N; k++) v[k] = $signed($urandom);
      load(v);
      e = model();
      run_scan($sformatf("rand%0d", r), -1, e);
    end

    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
